// File: rtl/skinny_sched_pkg.sv
// Shared types and sizing for the SKINNY-64 masked S-box scheduler.
// Imported by the scheduler top and its per-share buffers.
package skinny_sched_pkg;

    localparam int NIBBLES       = 16;
    localparam int PIPE_DEPTH    = 4;
    localparam int RND_PER_STAGE = 12;
    localparam int RND_W         = RND_PER_STAGE * PIPE_DEPTH;
    localparam int NIB_W         = 4;
    localparam int STATE_W       = NIBBLES * NIB_W;
    localparam int IDX_W         = $clog2(NIBBLES);
    localparam int CNT_W         = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/skinny_share_buf.sv
// One share of the cipher state: bulk load, indexed nibble read and
// indexed nibble write-back. One instance per share keeps domains apart.
module skinny_share_buf
    import skinny_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [STATE_W-1:0] load_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [NIB_W-1:0]   rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [NIB_W-1:0]   wr_data,
    output logic [STATE_W-1:0] q
);

    logic [STATE_W-1:0] data;

    // NOTE: the buffer is reset too, so no share of a discarded state survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (wr_en) begin
            data[wr_idx*NIB_W +: NIB_W] <= wr_data;
        end
    end

    assign rd_data = data[rd_idx*NIB_W +: NIB_W];
    assign q       = data;

endmodule

// File: rtl/skinny_sbox_sched.sv
// Streams a 3-share SKINNY-64 state through the external 4-stage masked
// S-box pipeline, one nibble per randomness-enabled cycle, writing results back in place.
module skinny_sbox_sched
    import skinny_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_s1,
    input  logic [STATE_W-1:0] in_s2,
    input  logic [STATE_W-1:0] in_s3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_s1,
    output logic [STATE_W-1:0] out_s2,
    output logic [STATE_W-1:0] out_s3,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [RND_W-1:0]   rnd_in,
    output logic               sb_en,
    output logic [RND_W-1:0]   sb_r,
    output logic [NIB_W-1:0]   sb_in1,
    output logic [NIB_W-1:0]   sb_in2,
    output logic [NIB_W-1:0]   sb_in3,
    input  logic [NIB_W-1:0]   sb_out1,
    input  logic [NIB_W-1:0]   sb_out2,
    input  logic [NIB_W-1:0]   sb_out3,
    output logic               busy
);

    state_t                state, state_next;
    logic [CNT_W-1:0]      issue_cnt, cap_cnt;
    logic [PIPE_DEPTH-1:0] tag;
    logic                  load, run_en, issue_active, capture;
    logic [NIB_W-1:0]      rd1, rd2, rd3;
    logic [STATE_W-1:0]    q1, q2, q3;

    assign run_en       = (state == RUN) && rnd_valid;
    assign issue_active = (state == RUN) && (issue_cnt < CNT_W'(NIBBLES));
    // The oldest tag bit marks a valid result leaving the pipeline this cycle.
    assign capture      = run_en && tag[PIPE_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (capture && cap_cnt == CNT_W'(NIBBLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            tag       <= '0;
        end else if (load) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            tag       <= '0;
        end else if (run_en) begin
            tag <= {tag[PIPE_DEPTH-2:0], issue_active};
            if (issue_active) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (tag[PIPE_DEPTH-1]) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
        end
    end

    skinny_share_buf u_buf1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s1),
        .rd_idx(issue_cnt[IDX_W-1:0]), .rd_data(rd1),
        .wr_en(capture), .wr_idx(cap_cnt[IDX_W-1:0]), .wr_data(sb_out1), .q(q1)
    );

    skinny_share_buf u_buf2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s2),
        .rd_idx(issue_cnt[IDX_W-1:0]), .rd_data(rd2),
        .wr_en(capture), .wr_idx(cap_cnt[IDX_W-1:0]), .wr_data(sb_out2), .q(q2)
    );

    skinny_share_buf u_buf3 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_data(in_s3),
        .rd_idx(issue_cnt[IDX_W-1:0]), .rd_data(rd3),
        .wr_en(capture), .wr_idx(cap_cnt[IDX_W-1:0]), .wr_data(sb_out3), .q(q3)
    );

    // Bubbles and idle slots are constant zero, never a value derived from a share.
    assign sb_in1    = issue_active ? rd1 : '0;
    assign sb_in2    = issue_active ? rd2 : '0;
    assign sb_in3    = issue_active ? rd3 : '0;

    assign sb_en     = run_en;
    assign rnd_ready = run_en;
    assign sb_r      = (state == RUN) ? rnd_in : '0;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_s1    = (state == DONE) ? q1 : '0;
    assign out_s2    = (state == DONE) ? q2 : '0;
    assign out_s3    = (state == DONE) ? q3 : '0;

endmodule
